// File: rtl/pin_uart_pkg.sv
// Shared definitions for the PIN-entry UART path (receiver, transmitter, PIN checker).
// Keeping the baud divisor here means every side of the link runs at the same bit rate.
package pin_uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;   // 12 MHz / 115200

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/pin_sync.sv
// N-flop synchroniser for an asynchronous serial line; resets to 1 so that
// an idle-high UART line does not look like a start bit after reset.
module pin_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '1;
        end else begin
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/pin_uart_rx.sv
// 8N1 UART receiver feeding the PIN checker: mid-bit 2-of-3 majority sampling,
// one-cycle VALID / FRAME_ERR strobes, and break suppression after a framing error.
module pin_uart_rx
    import pin_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] VOTE_A   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] VOTE_B   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] VOTE_C   = CNT_W'(MID + 1);
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(DATA_BITS);

    logic                 rxs;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 vote_a;
    logic                 vote_b;
    logic                 maj;

    pin_sync #(.N(SYNC_STAGES)) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (RX),
        .q     (rxs)
    );

    assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    // Third vote is the live sample taken at MID+1, when the decision is made.
    assign maj     = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);
    assign BUSY    = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            vote_a    <= 1'b1;
            vote_b    <= 1'b1;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (cnt == VOTE_A) vote_a <= rxs;
            if (cnt == VOTE_B) vote_b <= rxs;

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                // The bit counter keeps running from the start edge into the data
                // phase, so every data/stop sample lands mid-bit rather than near
                // the leading edge.
                S_START: begin
                    cnt <= cnt_nxt;
                    if (cnt == VOTE_C) begin
                        if (maj) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    cnt <= cnt_nxt;
                    if (cnt == VOTE_C) begin
                        shreg[bit_idx[IDX_W-2:0]] <= maj;
                        bit_idx                   <= bit_idx + 1'b1;
                    end
                    if (cnt == CNT_LAST && bit_idx == IDX_DONE) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    cnt <= cnt_nxt;
                    if (cnt == VOTE_C) begin
                        if (maj) begin
                            VALID <= 1'b1;
                            DATA  <= shreg;
                            state <= S_IDLE;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_WAIT_HIGH;
                        end
                    end
                end
                // A held-low line (break) must not be decoded as a stream of 0x00.
                S_WAIT_HIGH: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_uart_rx.sv
// Self-checking bench for pin_uart_rx: serial frames are generated bit-by-bit and
// the received byte stream is compared with the queue of bytes that were sent.
module tb_pin_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int MID  = CPB / 2;
    localparam int LAT  = SYNC + 9 * CPB + MID + 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       RX;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       BUSY;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pin_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .RX        (RX),
        .DATA      (DATA),
        .VALID     (VALID),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    // Output monitor: records every VALID byte with its cycle, counts strobes.
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         fe_cnt  = 0;
    int         overlap = 0;
    int         wide    = 0;
    logic       prev_v  = 1'b0;
    logic       prev_f  = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (VALID === 1'b1) begin
            got_q.push_back(DATA);
            got_cyc.push_back(cyc);
        end
        if (FRAME_ERR === 1'b1) fe_cnt++;
        if (VALID === 1'b1 && FRAME_ERR === 1'b1) overlap++;
        if ((VALID === 1'b1 && prev_v) || (FRAME_ERR === 1'b1 && prev_f)) wide++;
        prev_v = (VALID === 1'b1);
        prev_f = (FRAME_ERR === 1'b1);
    end

    // Reference model: bytes expected in order, and the byte DATA should hold.
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    task automatic drive_bits(input logic v, input int n);
        RX = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b);
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
        drive_bits(1'b1, CPB);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b);
        exp_q.push_back(b);
        last_good = b;
    endtask

    task automatic test_reset();
        checks++; if (DATA !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", DATA); end
        checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", VALID); end
        checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", FRAME_ERR); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        RST_N = 1'b1;
        drive_bits(1'b1, 4 * CPB);
        checks++; if (BUSY !== 1'b0 || got_q.size() != 0) begin failures++; $display("FAIL idle_after_reset busy=%b valids=%0d exp busy=0 valids=0", BUSY, got_q.size()); end
    endtask

    task automatic test_single();
        int fe0, t0;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        fe0 = fe_cnt;
        t0  = cyc;
        send_good(8'hA5);
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", got_q[0]); end
            checks++;
            if (got_cyc[0] - (t0 + 1) < LAT - 1 || got_cyc[0] - (t0 + 1) > LAT + 1) begin
                failures++; $display("FAIL single_latency got=%0d exp=%0d+-1", got_cyc[0] - (t0 + 1), LAT);
            end
        end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", fe_cnt - fe0); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", BUSY); end
        checks++; if (DATA !== 8'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", DATA); end
    endtask

    task automatic test_back_to_back();
        int fe0;
        got_q.delete(); exp_q.delete();
        fe0 = fe_cnt;
        for (int i = 0; i < 4; i++) send_good(8'h31 + 8'(i));
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_glitch_start();
        int fe0;
        got_q.delete(); exp_q.delete();
        fe0 = fe_cnt;
        drive_bits(1'b0, 4);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL glitch_busy_set got=%b exp=1", BUSY); end
        drive_bits(1'b1, MID + 2);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL glitch_busy_clear got=%b exp=0", BUSY); end
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != 0 || fe_cnt != fe0) begin failures++; $display("FAIL glitch_no_pulse valids=%0d ferrs=%0d exp 0/0", got_q.size(), fe_cnt - fe0); end
        send_good(8'h55);
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h55) begin failures++; $display("FAIL glitch_then_55 count=%0d data=%h exp 1/55", got_q.size(), DATA); end
    endtask

    task automatic test_frame_err();
        int fe0;
        logic [7:0] prev;
        got_q.delete(); exp_q.delete();
        fe0  = fe_cnt;
        prev = last_good;
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bits(((8'h3C >> i) & 8'h01) != 0, CPB);
        drive_bits(1'b0, 3 * CPB);
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=0", got_q.size()); end
        checks++; if (DATA !== prev) begin failures++; $display("FAIL ferr_data_hold got=%h exp=%h", DATA, prev); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL ferr_busy_break got=%b exp=1", BUSY); end
        drive_bits(1'b1, CPB);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ferr_busy_release got=%b exp=0", BUSY); end
        send_good(8'h3C);
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin failures++; $display("FAIL ferr_recover count=%0d data=%h exp 1/3c", got_q.size(), DATA); end
    endtask

    task automatic test_data_glitch();
        got_q.delete(); exp_q.delete();
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bits(1'b1, CPB);
        drive_bits(1'b1, MID);
        drive_bits(1'b0, 1);
        drive_bits(1'b1, CPB - MID - 1);
        for (int i = 4; i < 8; i++) drive_bits(1'b1, CPB);
        drive_bits(1'b1, CPB);
        last_good = 8'hFF;
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != 1 || DATA !== 8'hFF) begin failures++; $display("FAIL bit_glitch count=%0d data=%h exp 1/ff", got_q.size(), DATA); end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        logic [7:0] b;
        got_q.delete(); exp_q.delete();
        b = {4'hF, 4'($urandom_range(0, 15))};
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bits(b[i], CPB);
        drive_bits(1'b1, MID);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (DATA !== 8'h00 || VALID !== 1'b0 || FRAME_ERR !== 1'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL midframe_reset data=%h v=%b fe=%b busy=%b exp 00/0/0/0", DATA, VALID, FRAME_ERR, BUSY);
        end
        RST_N = 1'b1;
        last_good = 8'h00;
        fe0 = fe_cnt;
        drive_bits(1'b1, CPB - MID - 2);
        drive_bits(1'b1, 4 * CPB);
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != 0 || fe_cnt != fe0) begin failures++; $display("FAIL midframe_discard valids=%0d ferrs=%0d exp 0/0", got_q.size(), fe_cnt - fe0); end
        checks++; if (DATA !== last_good) begin failures++; $display("FAIL midframe_data got=%h exp=%h", DATA, last_good); end
        send_good(8'h39);
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h39) begin failures++; $display("FAIL midframe_next count=%0d data=%h exp 1/39", got_q.size(), DATA); end
    endtask

    task automatic test_random();
        int fe0;
        got_q.delete(); exp_q.delete();
        fe0 = fe_cnt;
        for (int n = 0; n < 12; n++) begin
            send_good(8'($urandom_range(0, 255)));
            drive_bits(1'b1, $urandom_range(0, CPB));
        end
        drive_bits(1'b1, 2 * CPB);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL rand_ferr got=%0d exp=0", fe_cnt - fe0); end
        checks++; if (DATA !== last_good) begin failures++; $display("FAIL rand_hold got=%h exp=%h", DATA, last_good); end
    endtask

    task automatic test_strobes();
        checks++; if (overlap != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", overlap); end
        checks++; if (wide != 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", wide); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RX    = 1'b1;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch_start();
        test_frame_err();
        test_data_glitch();
        test_reset_midframe();
        test_random();
        test_strobes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
